// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and helpers for the cache-to-memory fill arbiter.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } fillState_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Mask that clears the byte-offset bits of a cache line.
  function automatic logic [31:0] lineBaseMask(input int lineWords, input int dataW);
    return ~(32'(lineWords * dataW / 8) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Request, fill-return and memory-side signals of the fill arbiter.
// master is the cache/memory side, slave is the arbiter.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int NUM_REQ    = 2,
  parameter int LINE_WORDS = 8
);
  localparam int CH_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF_W = $clog2(LINE_WORDS);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;

  logic                      fill_valid;
  logic [CH_W-1:0]           fill_ch;
  logic [OFF_W-1:0]          fill_offset;
  logic [DATA_W-1:0]         fill_data;
  logic                      fill_last;
  logic                      busy;

  logic                      mem_en;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_rvalid;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
    input  req_done, fill_valid, fill_ch, fill_offset, fill_data, fill_last,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
    output req_done, fill_valid, fill_ch, fill_offset, fill_data, fill_last,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fill_arbiter_rr.sv
// Request arbiter: fixed lowest-index priority or round-robin starting
// after the most recently granted channel.
module rr_arbiter
  import mem_fill_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MODE    = ARB_FIXED,
  parameter int CH_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_ptrEn,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [CH_W-1:0]    o_idx,
  output logic               o_any
);

  logic [CH_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [CH_W-1:0]    w_idx;
  logic               w_found;

  // Channel examined at search step k; round-robin rotates the start point.
  function automatic int candidate(input logic [CH_W-1:0] ptr, input int k);
    return (MODE == ARB_RR) ? ((int'(ptr) + k) % NUM_REQ) : k;
  endfunction

  // Pick the first requesting channel in search order.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[candidate(r_ptr, k)]) begin
        w_found                     = 1'b1;
        w_grant[candidate(r_ptr, k)] = 1'b1;
        w_idx                       = CH_W'(candidate(r_ptr, k));
      end
    end
  end

  // Move the pointer just past the channel that won, wrapping at NUM_REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_ptrEn && w_found) begin
      r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + CH_W'(1);
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = w_found;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Memory front end for the L1 caches: one channel at a time is granted,
// stores go out as single-word writes, misses as pipelined line bursts.
module mem_fill_arbiter
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int NUM_REQ    = 2,
  parameter int LINE_WORDS = 8,
  parameter int MEM_LAT    = 4,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input logic clk,
  input logic rst,
  mem_fill_arbiter_if.slave bus
);

  localparam int CH_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(lineBaseMask(LINE_WORDS, DATA_W));

  fillState_t         r_state;
  logic [CH_W-1:0]    r_ch;
  logic [ADDR_W-1:0]  r_lineBase;
  logic [CNT_W-1:0]   r_issueCnt;
  logic [OFF_W-1:0]   r_retCnt;

  logic [NUM_REQ-1:0] r_reqDone;
  logic               r_fillValid;
  logic [CH_W-1:0]    r_fillCh;
  logic [OFF_W-1:0]   r_fillOffset;
  logic [DATA_W-1:0]  r_fillData;
  logic               r_fillLast;
  logic               r_memEn;
  logic               r_memWr;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [DATA_W-1:0]  r_memWdata;

  logic [NUM_REQ-1:0] w_grant;
  logic [CH_W-1:0]    w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_reqAddr;
  logic [DATA_W-1:0]  w_reqWdata;
  logic [ADDR_W-1:0]  w_issueAddr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MODE    (ARB_MODE),
    .CH_W    (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.req_valid),
    .i_ptrEn (r_state == IDLE),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_reqAddr   = bus.req_addr[int'(w_idx) * ADDR_W +: ADDR_W];
  assign w_reqWdata  = bus.req_wdata[int'(w_idx) * DATA_W +: DATA_W];
  assign w_issueAddr = r_lineBase + ADDR_W'(int'(r_issueCnt) * BYTES);

  // Controller: grant in IDLE, one-cycle WRITE, FILL issues the whole line
  // back to back while registering returned words as they arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_lineBase   <= '0;
      r_issueCnt   <= '0;
      r_retCnt     <= '0;
      r_reqDone    <= '0;
      r_fillValid  <= 1'b0;
      r_fillCh     <= '0;
      r_fillOffset <= '0;
      r_fillData   <= '0;
      r_fillLast   <= 1'b0;
      r_memEn      <= 1'b0;
      r_memWr      <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
    end else begin
      r_reqDone   <= '0;
      r_fillValid <= 1'b0;
      r_fillLast  <= 1'b0;
      r_memEn     <= 1'b0;
      r_memWr     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ch       <= w_idx;
            r_lineBase <= w_reqAddr & LINE_MASK;
            r_retCnt   <= '0;
            r_memEn    <= 1'b1;
            if (bus.req_write[w_idx]) begin
              r_state    <= WRITE;
              r_memWr    <= 1'b1;
              r_memAddr  <= w_reqAddr;
              r_memWdata <= w_reqWdata;
              r_reqDone  <= w_grant;
            end else begin
              r_state    <= FILL;
              r_memAddr  <= w_reqAddr & LINE_MASK;
              r_issueCnt <= CNT_W'(1);
            end
          end
        end
        WRITE: begin
          r_state <= IDLE;
        end
        FILL: begin
          if (r_issueCnt < CNT_W'(LINE_WORDS)) begin
            r_memEn    <= 1'b1;
            r_memAddr  <= w_issueAddr;
            r_issueCnt <= r_issueCnt + CNT_W'(1);
          end
          if (r_fillLast) begin
            r_state <= IDLE;
          end else if (bus.mem_rvalid) begin
            r_fillValid  <= 1'b1;
            r_fillData   <= bus.mem_rdata;
            r_fillOffset <= r_retCnt;
            r_fillCh     <= r_ch;
            r_retCnt     <= r_retCnt + OFF_W'(1);
            if (r_retCnt == OFF_W'(LINE_WORDS - 1)) begin
              r_fillLast <= 1'b1;
              r_reqDone  <= NUM_REQ'(1) << r_ch;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_done    = r_reqDone;
  assign bus.fill_valid  = r_fillValid;
  assign bus.fill_ch     = r_fillCh;
  assign bus.fill_offset = r_fillOffset;
  assign bus.fill_data   = r_fillData;
  assign bus.fill_last   = r_fillLast;
  assign bus.busy        = (r_state != IDLE);
  assign bus.mem_en      = r_memEn;
  assign bus.mem_wr      = r_memWr;
  assign bus.mem_addr    = r_memAddr;
  assign bus.mem_wdata   = r_memWdata;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: a fixed-priority two-channel instance with a
// latency model of memory, plus a four-channel round-robin instance.
module tb_mem_fill_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int LW       = 8;
  localparam int LAT      = 4;
  localparam int FILL_LAT = 1 + LW + LAT;
  localparam int WR_LAT   = 1;

  typedef struct {
    logic        wr;
    int          ch;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          expLat;
  } vec_t;

  typedef struct {
    int          ch;
    int          off;
    logic [15:0] data;
    logic        last;
  } fillExp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wrExp_t;

  logic clk = 1'b0;
  logic rst;
  logic strayValid;

  always #5 clk = ~clk;

  mem_fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(2), .LINE_WORDS(LW)) bus0();
  mem_fill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(4), .LINE_WORDS(LW)) bus1();

  mem_fill_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(2), .LINE_WORDS(LW), .MEM_LAT(LAT), .ARB_MODE(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_fill_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(4), .LINE_WORDS(LW), .MEM_LAT(LAT), .ARB_MODE(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Memory model: every read issue comes back LAT cycles later as addr^A5A5.
  bit          pipeV [LAT];
  bit [AW-1:0] pipeA [LAT];

  always @(posedge clk) begin
    pipeV[0] <= (bus0.mem_en === 1'b1) && (bus0.mem_wr === 1'b0);
    pipeA[0] <= bus0.mem_addr;
    for (int k = 1; k < LAT; k++) begin
      pipeV[k] <= pipeV[k-1];
      pipeA[k] <= pipeA[k-1];
    end
  end

  assign bus0.mem_rvalid = pipeV[LAT-1] | strayValid;
  assign bus0.mem_rdata  = pipeA[LAT-1] ^ 16'hA5A5;
  assign bus1.mem_rvalid = 1'b0;
  assign bus1.mem_rdata  = '0;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] issueQ [$];
  fillExp_t    fillQ  [$];
  wrExp_t      writeQ [$];

  int cyc;
  int doneCyc [2];
  int doneCnt [2];
  int firstIssue;
  int firstFill;
  int fillCnt;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every memory access and fill word is matched against the
  // expectations queued when the request was driven.
  always @(negedge clk) begin
    fillExp_t f;
    wrExp_t   w;
    if (bus0.mem_en === 1'b1) begin
      if (bus0.mem_wr === 1'b1) begin
        if (writeQ.size() == 0) begin
          checkOutput("write_unexpected", 32'(bus0.mem_en), 0);
        end else begin
          w = writeQ.pop_front();
          checkOutput("write_addr", 32'(bus0.mem_addr), 32'(w.addr));
          checkOutput("write_data", 32'(bus0.mem_wdata), 32'(w.data));
        end
      end else begin
        if (issueQ.size() == 0) begin
          checkOutput("issue_unexpected", 32'(bus0.mem_en), 0);
        end else begin
          checkOutput("issue_addr", 32'(bus0.mem_addr), 32'(issueQ.pop_front()));
        end
      end
    end
    if (bus0.fill_valid === 1'b1) begin
      if (fillQ.size() == 0) begin
        checkOutput("fill_unexpected", 32'(bus0.fill_valid), 0);
      end else begin
        f = fillQ.pop_front();
        checkOutput("fill_ch", 32'(bus0.fill_ch), f.ch);
        checkOutput("fill_offset", 32'(bus0.fill_offset), f.off);
        checkOutput("fill_data", 32'(bus0.fill_data), 32'(f.data));
        checkOutput("fill_last", 32'(bus0.fill_last), 32'(f.last));
      end
    end
  end

  task automatic startSeq();
    cyc        = 0;
    firstIssue = -1;
    firstFill  = -1;
    fillCnt    = 0;
    for (int c = 0; c < 2; c++) begin
      doneCyc[c] = -1;
      doneCnt[c] = 0;
    end
  endtask

  // Advance one cycle, log events, and release a request once it is done.
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (bus0.req_done[c] === 1'b1) begin
        if (doneCyc[c] < 0) doneCyc[c] = cyc;
        doneCnt[c]++;
        bus0.req_valid[c] = 1'b0;
      end
    end
    if (bus0.mem_en === 1'b1 && firstIssue < 0) firstIssue = cyc;
    if (bus0.fill_valid === 1'b1) begin
      fillCnt++;
      if (firstFill < 0) firstFill = cyc;
    end
  endtask

  task automatic waitDone(input int ch, input int budget);
    while (doneCyc[ch] < 0 && cyc < budget) stepCycle();
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [15:0] base;
    logic [15:0] a;
    fillExp_t    f;
    wrExp_t      w;
    bus0.req_valid[v.ch]             = 1'b1;
    bus0.req_write[v.ch]             = v.wr;
    bus0.req_addr[v.ch*AW +: AW]     = v.addr;
    bus0.req_wdata[v.ch*DW +: DW]    = v.wdata;
    if (v.wr) begin
      w.addr = v.addr;
      w.data = v.wdata;
      writeQ.push_back(w);
    end else begin
      base = v.addr & 16'hFFF0;
      for (int i = 0; i < LW; i++) begin
        a = base + 16'(2 * i);
        issueQ.push_back(a);
        f.ch   = v.ch;
        f.off  = i;
        f.data = a ^ 16'hA5A5;
        f.last = (i == LW - 1);
        fillQ.push_back(f);
      end
    end
  endtask

  vec_t vecs [6];
  int   grants [$];
  int   rrOrder [5] = '{0, 1, 2, 3, 0};

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 1, 16'h1236, 16'h0000, FILL_LAT};
    vecs[1] = '{1'b1, 0, 16'h0040, 16'hBEEF, WR_LAT};
    vecs[2] = '{1'b0, 0, 16'h00FE, 16'h0000, FILL_LAT};
    vecs[3] = '{1'b1, 1, 16'hFFFF, 16'h0001, WR_LAT};
    vecs[4] = '{1'b0, 1, 16'hFFF0, 16'h0000, FILL_LAT};
    vecs[5] = '{1'b1, 0, 16'h0000, 16'h1234, WR_LAT};

    rst             = 1'b1;
    strayValid      = 1'b0;
    bus0.req_valid  = '0;
    bus0.req_write  = '0;
    bus0.req_addr   = '0;
    bus0.req_wdata  = '0;
    bus1.req_valid  = '0;
    bus1.req_write  = '0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus0.busy), 0);
    checkOutput("reset_mem_en", 32'(bus0.mem_en), 0);
    checkOutput("reset_mem_wr", 32'(bus0.mem_wr), 0);
    checkOutput("reset_mem_addr", 32'(bus0.mem_addr), 0);
    checkOutput("reset_req_done", 32'(bus0.req_done), 0);
    checkOutput("reset_fill_valid", 32'(bus0.fill_valid), 0);
    checkOutput("reset_fill_last", 32'(bus0.fill_last), 0);
    checkOutput("reset_rr_busy", 32'(bus1.busy), 0);
    rst = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      startSeq();
      applyStimulus(v);
      waitDone(v.ch, 40);
      checkOutput($sformatf("v%0d_latency", i), doneCyc[v.ch], v.expLat);
      checkOutput($sformatf("v%0d_first_issue", i), firstIssue, 1);
      checkOutput($sformatf("v%0d_other_done", i), doneCnt[1 - v.ch], 0);
      if (!v.wr) begin
        checkOutput($sformatf("v%0d_first_fill", i), firstFill, 2 + LAT);
        checkOutput($sformatf("v%0d_fill_count", i), fillCnt, LW);
      end
      stepCycle();
      checkOutput($sformatf("v%0d_busy_after", i), 32'(bus0.busy), 0);
      checkOutput($sformatf("v%0d_done_once", i), doneCnt[v.ch], 1);
    end

    // Simultaneous writes: channel 0 first, channel 1 on the next IDLE cycle.
    startSeq();
    applyStimulus('{1'b1, 0, 16'h0100, 16'h1111, WR_LAT});
    applyStimulus('{1'b1, 1, 16'h0200, 16'h2222, WR_LAT});
    while (cyc < 6) stepCycle();
    checkOutput("prio_ch0_done", doneCyc[0], 1);
    checkOutput("prio_ch1_done", doneCyc[1], 3);
    checkOutput("prio_busy_after", 32'(bus0.busy), 0);

    // Channel 1 drops its request mid-fill while channel 0 asks to write.
    startSeq();
    applyStimulus('{1'b0, 1, 16'h3008, 16'h0000, FILL_LAT});
    while (cyc < 3) stepCycle();
    bus0.req_valid[1] = 1'b0;
    applyStimulus('{1'b1, 0, 16'h0300, 16'hCAFE, WR_LAT});
    while (cyc < 20) stepCycle();
    checkOutput("drop_fill_count", fillCnt, LW);
    checkOutput("drop_ch1_done", doneCyc[1], FILL_LAT);
    checkOutput("drop_ch1_once", doneCnt[1], 1);
    checkOutput("wait_ch0_done", doneCyc[0], FILL_LAT + 2);
    checkOutput("wait_ch0_once", doneCnt[0], 1);

    // Reset in the middle of a fill, then stray returns, then a clean fill.
    startSeq();
    applyStimulus('{1'b0, 0, 16'h4444, 16'h0000, FILL_LAT});
    while (cyc < 4) stepCycle();
    rst = 1'b1;
    bus0.req_valid[0] = 1'b0;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst_issues_left", issueQ.size(), LW - 4);
    issueQ.delete();
    fillQ.delete();
    checkOutput("rst_busy", 32'(bus0.busy), 0);
    checkOutput("rst_mem_en", 32'(bus0.mem_en), 0);
    checkOutput("rst_mem_addr", 32'(bus0.mem_addr), 0);
    checkOutput("rst_fill_valid", 32'(bus0.fill_valid), 0);
    checkOutput("rst_req_done", 32'(bus0.req_done), 0);
    while (cyc < 7) stepCycle();
    strayValid = 1'b1;
    stepCycle();
    strayValid = 1'b0;
    while (cyc < 12) stepCycle();
    checkOutput("stray_fill_count", fillCnt, 0);
    checkOutput("stray_busy", 32'(bus0.busy), 0);
    startSeq();
    applyStimulus('{1'b0, 1, 16'h5550, 16'h0000, FILL_LAT});
    waitDone(1, 40);
    checkOutput("post_rst_latency", doneCyc[1], FILL_LAT);
    checkOutput("post_rst_first_fill", firstFill, 2 + LAT);
    checkOutput("post_rst_fill_count", fillCnt, LW);
    stepCycle();

    // Round-robin instance with all four channels writing continuously.
    bus1.req_write = 4'hF;
    for (int c = 0; c < 4; c++) begin
      bus1.req_addr[c*AW +: AW]  = 16'h1000 + 16'(c * 16);
      bus1.req_wdata[c*DW +: DW] = 16'(c + 1);
    end
    bus1.req_valid = 4'hF;
    for (int t = 0; t < 40 && grants.size() < 5; t++) begin
      @(negedge clk);
      if (bus1.req_done !== 4'b0000) begin
        checkOutput("rr_onehot", $countones(bus1.req_done), 1);
        for (int c = 0; c < 4; c++) begin
          if (bus1.req_done[c] === 1'b1) grants.push_back(c);
        end
        checkOutput("rr_mem_addr", 32'(bus1.mem_addr), 32'(16'h1000 + 16'(grants[$] * 16)));
      end
    end
    bus1.req_valid = 4'h0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : -1, rrOrder[i]);
    end

    repeat (3) @(negedge clk);
    checkOutput("left_issues", issueQ.size(), 0);
    checkOutput("left_fills", fillQ.size(), 0);
    checkOutput("left_writes", writeQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Parametrised multi-requestor memory front end between the L1 caches and main memory.
- Arbitrates NUM_REQ requestors. Channel 0 is the D-cache and channel 1 is the I-cache.
- Each read miss is served as a pipelined burst line fill; each write-through store is served as a single-word write.
- Generalises the existing two-cache fill FSM in channel count, line size, memory latency and arbitration mode, and adds pipelined issue and round-robin fairness.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- NUM_REQ, 2, requestor count (>=1).
- LINE_WORDS, 8, words per cache line (power of 2, >=2).
- MEM_LAT, 4, memory cycles from issue to mem_rvalid (>=1).
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last granted channel.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, NUM_REQ, request pending per channel; held until req_done.
- req_write, in, NUM_REQ, 1 = single-word write, 0 = line fill.
- req_addr, in, NUM_REQ*ADDR_W, packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata, in, NUM_REQ*DATA_W, packed write data.
- req_done, out, NUM_REQ, one-cycle completion pulse per channel.
- fill_valid, out, 1, fill word valid.
- fill_ch, out, $clog2(NUM_REQ) (min 1), destination channel of the fill word.
- fill_offset, out, $clog2(LINE_WORDS), word index within the line.
- fill_data, out, DATA_W, fill word.
- fill_last, out, 1, final word of the line.
- busy, out, 1, state != IDLE.
- mem_en, out, 1, memory access strobe.
- mem_wr, out, 1, write strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_rvalid, in, 1, read data valid; asserted MEM_LAT cycles after each read issue.

Behaviour:
- Reset:
  - All outputs 0. State IDLE. Issue and return counters 0. Round-robin pointer 0.
  - Reset mid-fill abandons the burst. mem_rvalid pulses still in flight are ignored, because IDLE ignores mem_rvalid.
- States: IDLE, WRITE, FILL.
- IDLE:
  - If any req_valid is set, grant one channel per ARB_MODE.
  - Latch the channel, address and wdata. Go to WRITE if req_write, else FILL.
  - Grant decisions use only the IDLE-cycle inputs.
- WRITE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr=latched addr, mem_wdata=latched data.
  - req_done[ch]=1 in the same cycle; next state IDLE.
  - Write latency from request seen to done: 1 cycle.
- FILL:
  - Line base = addr with the low $clog2(LINE_WORDS*DATA_W/8) bits cleared.
  - Issue phase: issue one read per cycle for LINE_WORDS cycles. mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt. Addresses stay inside the aligned line, so no wrap.
  - Return phase: each mem_rvalid in FILL is registered into fill_valid/fill_data/fill_offset (return count) and fill_ch on the next cycle. Words arrive in order.
  - When the registered word has offset LINE_WORDS-1: fill_last=1 and req_done[ch]=1 in that cycle; next state IDLE.
  - Read latency: request seen at cycle t; issues at t+1..t+LINE_WORDS; fill words at t+2+MEM_LAT .. t+1+LINE_WORDS+MEM_LAT.
- Boundaries:
  - Requester dropping req_valid mid-fill does not abort; done still pulses.
  - A new request that arrives while busy waits; no preemption.
  - A channel re-requesting in the cycle after its done is legal and re-arbitrated.
  - Round-robin pointer advances to the granted channel +1, mod NUM_REQ.
  - NUM_REQ=1 degenerates to a pass-through with fill_ch=0.
- mem_rvalid outside FILL is ignored; a return count overflow cannot occur.

Decomposition:
- Package mem_fill_pkg: state enum (IDLE/WRITE/FILL), ARB_FIXED/ARB_RR constants, and a line-base mask function.
- One sub-module: rr_arbiter (NUM_REQ, MODE) covering request vector, pointer update enable, one-hot grant and encoded index.
- FSM, counters and memory muxing stay in the top module.

Test Plan (LINE_WORDS=8, MEM_LAT=4, model memory returns addr^16'hA5A5):
- Fill: ch1 read 0x1236 seen at cycle 0 -> mem_addr 0x1230, 0x1232..0x123E on cycles 1-8; fill_valid cycles 6-13 with offsets 0-7 and data 0xB795..0xB79B pattern; fill_last and req_done=2'b10 at cycle 13; busy low at 14.
- Write: ch0 write 0x0040 data 0xBEEF -> cycle 1 mem_en=1, mem_wr=1, addr 0x0040, wdata 0xBEEF, req_done=2'b01; busy low at cycle 2.
- Fixed priority (ARB_MODE=0): ch0 and ch1 request simultaneously -> ch0 served first, ch1 granted the first IDLE cycle after ch0 done.
- Round-robin (ARB_MODE=1, NUM_REQ=4): all four held continuously -> grant order 0,1,2,3,0.
- Reset: rst at cycle 4 of a fill -> outputs 0 at cycle 5; stray mem_rvalid pulses ignored; a fresh request completes normally with offsets starting at 0.
- Drop: ch1 deasserts req_valid at cycle 3 of a fill -> all 8 words still delivered, req_done[1] pulses once.
